cmd_frame_tx: RTL and testbench

Transmit-side command framer for the switch-board UART link. It accepts a single command request (destination board ID plus opcode) and builds the 8-byte frame EB 90 SEQ ID OP CHK 09 D7, where SEQ+ID+OP+CHK ≡ 0 mod 256. It pushes the bytes one at a time into the UART transmit FIFO and applies backpressure from the FIFO fill counter. It sits between the local control logic and the UART TX FIFO, and is the counterpart of the command-frame decoder.

---
 rtl/cmd_frame_defs_pkg.sv | 69 ++++++
 rtl/cmd_frame_tx_pacer.sv | 42 ++++
 rtl/cmd_frame_tx.sv | 118 +++++++++++
 tb/tb_cmd_frame_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_defs_pkg.sv
// Shared constants, state encoding and frame-building helpers for the command framer.
// Provides the default UART FIFO counter width when the UART defines are not already loaded.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package cmd_frame_defs;

  localparam int unsigned PUSH_GAP_DEF   = 2;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned CNT_W          = `UART_FIFO_COUNTER_W;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned IDX_W          = 3;

  localparam logic [BYTE_W-1:0] HDR0  = 8'hEB;
  localparam logic [BYTE_W-1:0] HDR1  = 8'h90;
  localparam logic [BYTE_W-1:0] TAIL0 = 8'h09;
  localparam logic [BYTE_W-1:0] TAIL1 = 8'hD7;

  localparam logic [BYTE_W-1:0] SWITCH_BOARD_ID = 8'hAB;

  localparam logic [BYTE_W-1:0] OP_0A = 8'h0A;
  localparam logic [BYTE_W-1:0] OP_0B = 8'h0B;
  localparam logic [BYTE_W-1:0] OP_A0 = 8'hA0;
  localparam logic [BYTE_W-1:0] OP_B0 = 8'hB0;
  localparam logic [BYTE_W-1:0] OP_AB = 8'hAB;
  localparam logic [BYTE_W-1:0] OP_BA = 8'hBA;
  localparam logic [BYTE_W-1:0] OP_AA = 8'hAA;
  localparam logic [BYTE_W-1:0] OP_55 = 8'h55;
  localparam logic [BYTE_W-1:0] OP_BB = 8'hBB;
  localparam logic [BYTE_W-1:0] OP_44 = 8'h44;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_SEND = 5'b00100,
    ST_GAP  = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

  // Checksum making SEQ+ID+OP+CHK wrap to zero.
  function automatic logic [BYTE_W-1:0] frame_chk(input logic [BYTE_W-1:0] s,
                                                  input logic [BYTE_W-1:0] id,
                                                  input logic [BYTE_W-1:0] op);
    logic [BYTE_W-1:0] sum;
    sum = BYTE_W'(s + id + op);
    return BYTE_W'(BYTE_W'(0) - sum);
  endfunction

  function automatic logic [BYTE_W-1:0] frame_byte(input logic [IDX_W-1:0]  idx,
                                                   input logic [BYTE_W-1:0] s,
                                                   input logic [BYTE_W-1:0] id,
                                                   input logic [BYTE_W-1:0] op,
                                                   input logic [BYTE_W-1:0] chk);
    logic [BYTE_W-1:0] b;
    case (idx)
      3'd0:    b = HDR0;
      3'd1:    b = HDR1;
      3'd2:    b = s;
      3'd3:    b = id;
      3'd4:    b = op;
      3'd5:    b = chk;
      3'd6:    b = TAIL0;
      default: b = TAIL1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cmd_frame_tx_pacer.sv
// cmd_frame_pacer: FIFO backpressure check and post-push gap counter for the framer.
// The push strobe is combinational so a full FIFO stalls exactly the cycles it is full.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module cmd_frame_pacer
  import cmd_frame_defs::*;
#(
  parameter int unsigned PUSH_GAP   = PUSH_GAP_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_send,
  input  logic             i_gap,
  input  logic [CNT_W-1:0] i_tf_counter,
  output logic             o_push,
  output logic             o_byte_taken
);

  localparam int unsigned GAP_W = (PUSH_GAP > 1) ? $clog2(PUSH_GAP) : 1;

  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_space;

  assign w_space      = (i_tf_counter < CNT_W'(FIFO_DEPTH));
  assign o_push       = i_send & w_space;
  // Last gap cycle: the byte has been paced out and the framer may move on.
  assign o_byte_taken = i_gap & (r_gap_cnt == GAP_W'(PUSH_GAP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (o_push) begin
      r_gap_cnt <= '0;
    end else if (i_gap) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: builds EB 90 SEQ ID OP CHK 09 D7 frames and paces them into the UART TX FIFO.
// Optional feature macro CMD_FRAME_TX_SEQ_EN enables the per-frame sequence counter.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module cmd_frame_tx
  import cmd_frame_defs::*;
#(
  parameter int unsigned PUSH_GAP   = PUSH_GAP_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic [7:0]                      dest_id,
  input  logic [7:0]                      opcode,
  input  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter,
  output logic                            ready,
  output logic                            tf_push,
  output logic [7:0]                      tdr,
  output logic                            done,
  output logic [7:0]                      seq
);

  state_e            r_state;
  state_e            w_next;
  logic [BYTE_W-1:0] r_id;
  logic [BYTE_W-1:0] r_op;
  logic [BYTE_W-1:0] r_chk;
  logic [BYTE_W-1:0] r_tdr;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] w_seq;
  logic              w_push;
  logic              w_byte_taken;
  logic              w_accept;

`ifdef CMD_FRAME_TX_SEQ_EN
  logic [BYTE_W-1:0] r_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq <= '0;
    end else if (r_state == ST_DONE) begin
      r_seq <= r_seq + BYTE_W'(1);
    end
  end

  assign w_seq = r_seq;
`else
  assign w_seq = 8'h00;
`endif

  assign w_accept = req & (r_state == ST_IDLE);

  cmd_frame_pacer #(
    .PUSH_GAP   (PUSH_GAP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_pacer (
    .clk          (clk),
    .rst          (rst),
    .i_send       (r_state == ST_SEND),
    .i_gap        (r_state == ST_GAP),
    .i_tf_counter (tf_counter),
    .o_push       (w_push),
    .o_byte_taken (w_byte_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: if (w_push) w_next = ST_GAP;
      ST_GAP:  if (w_byte_taken) w_next = (r_idx == IDX_W'(7)) ? ST_DONE : ST_LOAD;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame fields are captured once at acceptance and held until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id  <= '0;
      r_op  <= '0;
      r_chk <= '0;
      r_idx <= '0;
      r_tdr <= '0;
    end else begin
      if (w_accept) begin
        r_id  <= dest_id;
        r_op  <= opcode;
        r_chk <= frame_chk(w_seq, dest_id, opcode);
        r_idx <= '0;
      end else if ((r_state == ST_GAP) && w_byte_taken && (r_idx != IDX_W'(7))) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == ST_LOAD) begin
        r_tdr <= frame_byte(r_idx, w_seq, r_id, r_op, r_chk);
      end
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign tf_push = w_push;
  assign tdr     = r_tdr;
  assign seq     = w_seq;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed self-checking bench for cmd_frame_tx: framing, cadence, backpressure,
// seq wrap, mid-frame reset and ignored requests.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module tb_cmd_frame_tx;

`ifdef CMD_FRAME_TX_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif
  localparam int unsigned DEPTH = 16;

  logic                            clk;
  logic                            rst;
  logic                            req;
  logic [7:0]                      dest_id;
  logic [7:0]                      opcode;
  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter;
  logic                            ready;
  logic                            tf_push;
  logic [7:0]                      tdr;
  logic                            done;
  logic [7:0]                      seq;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .dest_id    (dest_id),
    .opcode     (opcode),
    .tf_counter (tf_counter),
    .ready      (ready),
    .tf_push    (tf_push),
    .tdr        (tdr),
    .done       (done),
    .seq        (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [7:0] s, input logic [7:0] id,
                                           input logic [7:0] op);
    logic [7:0] sum;
    sum = 8'(s + id + op);
    return 8'(8'd0 - sum);
  endfunction

  // Runs one frame starting at a negedge with ready expected high.
  // Byte stall_b sees a full FIFO for stall_len cycles from its nominal push cycle.
  task automatic run_frame(input string tag, input logic [7:0] id, input logic [7:0] op,
                           input logic [63:0] exp_bytes, input int stall_b, input int stall_len,
                           input bit disturb, input logic [7:0] seq_after);
    int k;
    int exp_cyc;
    int stall_at;
    int exp_done;
    bit got_done;
    bit prev_push;
    chk({tag, "/ready_pre"}, 32'(ready), 32'd1);
    dest_id    = id;
    opcode     = op;
    req        = 1'b1;
    tf_counter = 5'd3;
    k          = 0;
    got_done   = 1'b0;
    prev_push  = 1'b0;
    stall_at   = 2 + 4 * stall_b;
    exp_done   = 33 + stall_len;
    for (int c = 1; c <= 120 && !got_done; c++) begin
      @(negedge clk);
      req = 1'b0;
      tf_counter = (c >= stall_at && c < stall_at + stall_len) ? 5'(DEPTH) : 5'd3;
      if (disturb && c >= 3 && c <= 20) begin
        req     = c[0];
        dest_id = 8'(c * 13);
        opcode  = ~8'(c);
      end
      #1;
      if (c == 1) begin
        chk({tag, "/ready_busy"}, 32'(ready), 32'd0);
        chk({tag, "/push_c1"}, 32'(tf_push), 32'd0);
      end
      if (tf_push) begin
        chk({tag, "/push_back2back"}, 32'(prev_push), 32'd0);
        if (k < 8) begin
          exp_cyc = 2 + 4 * k + ((k >= stall_b) ? stall_len : 0);
          chk({tag, "/push_cycle"}, 32'(c), 32'(exp_cyc));
          chk({tag, "/byte"}, 32'(tdr), 32'(exp_bytes[63 - 8 * k -: 8]));
        end else begin
          chk({tag, "/extra_push"}, 32'(k), 32'd7);
        end
        k++;
      end
      if (done) begin
        chk({tag, "/done_cycle"}, 32'(c), 32'(exp_done));
        chk({tag, "/push_count"}, 32'(k), 32'd8);
        got_done = 1'b1;
      end
      prev_push = tf_push;
    end
    if (!got_done) chk({tag, "/timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    #1;
    chk({tag, "/ready_post"}, 32'(ready), 32'd1);
    chk({tag, "/done_pulse"}, 32'(done), 32'd0);
    chk({tag, "/seq_post"}, 32'(seq), 32'(seq_after));
  endtask

  // Starts a frame and asserts rst in the cycle of the 4th push.
  task automatic run_reset_abort(input logic [7:0] id, input logic [7:0] op,
                                 input logic [31:0] exp_bytes);
    int k;
    dest_id    = id;
    opcode     = op;
    req        = 1'b1;
    tf_counter = 5'd0;
    k          = 0;
    for (int c = 1; c <= 60 && k < 4; c++) begin
      @(negedge clk);
      req = 1'b0;
      #1;
      if (tf_push) begin
        chk("abort/byte", 32'(tdr), 32'(exp_bytes[31 - 8 * k -: 8]));
        k++;
      end
    end
    chk("abort/pushes_before_rst", 32'(k), 32'd4);
    rst = 1'b1;
    #1;
    chk("abort/tf_push", 32'(tf_push), 32'd0);
    chk("abort/done", 32'(done), 32'd0);
    chk("abort/seq", 32'(seq), 32'd0);
    chk("abort/ready", 32'(ready), 32'd1);
    chk("abort/tdr", 32'(tdr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0]  s;
    logic [7:0]  op;
    logic [63:0] exp;
    rst        = 1'b1;
    req        = 1'b0;
    dest_id    = 8'h00;
    opcode     = 8'h00;
    tf_counter = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/ready", 32'(ready), 32'd1);
    chk("rst/tf_push", 32'(tf_push), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset/ready", 32'(ready), 32'd1);
    chk("reset/tf_push", 32'(tf_push), 32'd0);
    chk("reset/tdr", 32'(tdr), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/seq", 32'(seq), 32'd0);

    run_frame("f1", 8'hAB, 8'h0A, 64'hEB90_00AB_0A4B_09D7, 8, 0, 1'b0, SEQ_ON ? 8'h01 : 8'h00);
    run_frame("f2", 8'hAB, 8'h0B,
              SEQ_ON ? 64'hEB90_01AB_0B49_09D7 : 64'hEB90_00AB_0B4A_09D7,
              8, 0, 1'b0, SEQ_ON ? 8'h02 : 8'h00);
    run_frame("bp", 8'h12, 8'hA0,
              SEQ_ON ? 64'hEB90_0212_A04C_09D7 : 64'hEB90_0012_A04E_09D7,
              3, 10, 1'b0, SEQ_ON ? 8'h03 : 8'h00);
    run_frame("busy", 8'h33, 8'hBA,
              SEQ_ON ? 64'hEB90_0333_BA10_09D7 : 64'hEB90_0033_BA13_09D7,
              8, 0, 1'b1, SEQ_ON ? 8'h04 : 8'h00);

    run_reset_abort(8'h77, 8'hAA, SEQ_ON ? 32'hEB90_0477 : 32'hEB90_0077);
    run_frame("fresh", 8'hAB, 8'h44, 64'hEB90_00AB_4411_09D7, 8, 0, 1'b0,
              SEQ_ON ? 8'h01 : 8'h00);

    if (SEQ_ON) begin
      for (int i = 1; i < 255; i++) begin
        s   = 8'(i);
        op  = 8'(i * 5);
        exp = {8'hEB, 8'h90, s, 8'hAB, op, model_chk(s, 8'hAB, op), 8'h09, 8'hD7};
        run_frame("seq_run", 8'hAB, op, exp, 8, 0, 1'b0, 8'(i + 1));
      end
    end
    run_frame("wrap", 8'hAB, 8'h55,
              SEQ_ON ? 64'hEB90_FFAB_5501_09D7 : 64'hEB90_00AB_5500_09D7,
              8, 0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
